axi_ram: RTL and testbench

AXI4-Lite slave (responder) providing word-addressed on-chip RAM for the core's `code`, `data` or `peripheral` master ports. It terminates one `axi.slave` interface, with independent read and write paths, byte-strobe writes and error responses for out-of-window addresses. One instance sits behind each master port in the SoC top level.

---
 rtl/axi_ram_if.sv | 28 ++
 rtl/axi_ram.sv | 102 ++++++++++
 tb/tb_axi_ram.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_if.sv
// axi_ram_if: AXI4-Lite bus bundle with master and slave views
interface axi_ram_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_ram.sv
// axi_ram: AXI4-Lite word-addressed RAM with byte strobes and SLVERR outside its window
module axi_ram #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input logic        clk,
  input logic        resetn,
  axi_ram_if.slave   bus
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} rstate_t;
  logic [31:0] mem [DEPTH];
  wstate_t     wstate_q;
  rstate_t     rstate_q;
  logic        aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [31:2] awaddr_q, araddr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        aw_hs, w_hs, aw_in_win, ar_in_win;
  assign bus.awready = resetn & ~aw_held_q & ~bvalid_q;
  assign bus.wready  = resetn & ~w_held_q & ~bvalid_q;
  assign bus.arready = resetn & (rstate_q == R_IDLE);
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign aw_hs     = bus.awvalid & bus.awready;
  assign w_hs      = bus.wvalid & bus.wready;
  assign aw_in_win = awaddr_q[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH];
  assign ar_in_win = araddr_q[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= bus.awaddr[31:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= bus.wdata;
        wstrb_q  <= bus.wstrb;
      end
      case (wstate_q)
        W_IDLE: if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) wstate_q <= W_COMMIT;
        W_COMMIT: begin
          bvalid_q <= 1'b1;
          bresp_q  <= aw_in_win ? OKAY : SLVERR;
          wstate_q <= W_RESP;
        end
        W_RESP: if (bus.bready) begin
          bvalid_q  <= 1'b0;
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (wstate_q == W_COMMIT && aw_in_win)
      for (int i = 0; i < 4; i++)
        if (wstrb_q[i]) mem[awaddr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rstate_q <= R_IDLE;
      araddr_q <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (bus.arvalid) begin
          araddr_q <= bus.araddr[31:2];
          rstate_q <= R_READ;
        end
        R_READ: begin
          rdata_q  <= ar_in_win ? mem[araddr_q[ADDR_WIDTH-1:2]] : '0;
          rresp_q  <= ar_in_win ? OKAY : SLVERR;
          rvalid_q <= 1'b1;
          rstate_q <= R_RESP;
        end
        R_RESP: if (bus.rready) begin
          rvalid_q <= 1'b0;
          rstate_q <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_ram.sv
// tb_axi_ram: directed self-checking bench for axi_ram
module tb_axi_ram;
  logic clk, resetn;
  int   errors, checks;
  axi_ram_if bus ();
  axi_ram dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500us");
    $fatal(1);
  end
  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, output logic [1:0] resp);
    int  n;
    logic aw, w;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      aw = bus.awvalid && bus.awready;
      w  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw) bus.awvalid = 1'b0;
      if (w) bus.wvalid = 1'b0;
      n++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bus.bvalid);
    end
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    n = 0;
    while (!bus.arready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, bus.rvalid);
    end
    d = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b%b%b valid=%b%b resp=%b/%b rdata=%h required all 0",
               bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
    end
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b%b%b required 111", bus.awready, bus.wready, bus.arready);
    end
  endtask
  task automatic test_basic();
    logic [31:0] rd; logic [1:0] rr, br; int lat;
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, br);
    checks++;
    if (br !== 2'b00) begin errors++; $display("FAIL basic_bresp got=%b required 00", br); end
    do_read(32'h10, rd, rr, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rdata got=%h required deadbeef", rd); end
    checks++;
    if (rr !== 2'b00) begin errors++; $display("FAIL basic_rresp got=%b required 00", rr); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL basic_read_latency got=%0d required 1", lat); end
  endtask
  task automatic test_strobe();
    logic [31:0] rd; logic [1:0] rr, br; int lat;
    do_write(32'h20, 32'h1122_3344, 4'hF, br);
    do_write(32'h20, 32'hAABB_CCDD, 4'b0101, br);
    checks++;
    if (br !== 2'b00) begin errors++; $display("FAIL strobe_bresp got=%b required 00", br); end
    do_read(32'h20, rd, rr, lat);
    checks++;
    if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_rdata got=%h required 11bb33dd", rd); end
  endtask
  task automatic test_order(input logic aw_first, input logic [31:0] a, d);
    logic [31:0] rd; logic [1:0] rr; int lat;
    bus.bready = 1'b0; bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
    if (aw_first) bus.awvalid = 1'b1; else bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if ({bus.awready, bus.wready} !== (aw_first ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL order%0d_first_ready got aw/w=%b%b required %b", aw_first, bus.awready, bus.wready, aw_first ? 2'b01 : 2'b10);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL order%0d_early_bvalid got=%b required 0", aw_first, bus.bvalid); end
    if (aw_first) bus.wvalid = 1'b1; else bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL order%0d_commit_bvalid got=%b required 0", aw_first, bus.bvalid); end
    @(posedge clk); #1;
    checks++;
    if ({bus.bvalid, bus.bresp} !== 3'b100) begin
      errors++;
      $display("FAIL order%0d_bvalid got bvalid=%b bresp=%b required 1/00", aw_first, bus.bvalid, bus.bresp);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    checks++;
    if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
      errors++;
      $display("FAIL order%0d_complete got bvalid/aw/w=%b%b%b required 011", aw_first, bus.bvalid, bus.awready, bus.wready);
    end
    do_read(a, rd, rr, lat);
    checks++;
    if (rd !== d) begin errors++; $display("FAIL order%0d_rdata got=%h required %h", aw_first, rd, d); end
  endtask
  task automatic test_out_of_window();
    logic [31:0] rd; logic [1:0] rr, br; int lat;
    do_write(32'h0, 32'h55AA_55AA, 4'hF, br);
    do_write(32'h400, 32'hFFFF_FFFF, 4'hF, br);
    checks++;
    if (br !== 2'b10) begin errors++; $display("FAIL oow_bresp got=%b required 10", br); end
    do_read(32'h400, rd, rr, lat);
    checks++;
    if ({rr, rd} !== {2'b10, 32'h0}) begin errors++; $display("FAIL oow_read got rresp=%b rdata=%h required 10/00000000", rr, rd); end
    do_read(32'h0, rd, rr, lat);
    checks++;
    if ({rr, rd} !== {2'b00, 32'h55AA_55AA}) begin errors++; $display("FAIL oow_word0 got rresp=%b rdata=%h required 00/55aa55aa", rr, rd); end
  endtask
  task automatic test_backpressure();
    logic [31:0] rd; logic [1:0] rr; int lat;
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 32'h40; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.araddr = 32'h10;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({bus.bvalid, bus.bresp, bus.rvalid, bus.rresp, bus.rdata, bus.awready, bus.arready} !==
          {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got b=%b/%b r=%b/%b/%h awrdy=%b arrdy=%b required 1/00 1/00/deadbeef 0 0",
                 c, bus.bvalid, bus.bresp, bus.rvalid, bus.rresp, bus.rdata, bus.awready, bus.arready);
      end
      @(posedge clk); #1;
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.arready} !== 4'b0011) begin
      errors++;
      $display("FAIL bp_release got bvalid/rvalid/awrdy/arrdy=%b%b%b%b required 0011", bus.bvalid, bus.rvalid, bus.awready, bus.arready);
    end
    do_read(32'h40, rd, rr, lat);
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL bp_rdata got=%h required 12345678", rd); end
    bus.awaddr = 32'h40; bus.wdata = 32'h9999_0000; bus.araddr = 32'h40;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1; bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.rvalid, bus.rdata, bus.bvalid} !== {1'b1, 32'h1234_5678, 1'b1}) begin
      errors++;
      $display("FAIL read_first got rvalid=%b rdata=%h bvalid=%b required 1/12345678/1", bus.rvalid, bus.rdata, bus.bvalid);
    end
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_read(32'h40, rd, rr, lat);
    checks++;
    if (rd !== 32'h9999_0000) begin errors++; $display("FAIL read_first_after got=%h required 99990000", rd); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rr; int lat;
    bus.rready = 1'b0; bus.bready = 1'b0;
    bus.araddr = 32'h10; bus.arvalid = 1'b1; bus.awaddr = 32'h44; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.rvalid, bus.awready, bus.wready} !== 3'b101) begin
      errors++;
      $display("FAIL rstmid_setup got rvalid/awrdy/wrdy=%b%b%b required 101", bus.rvalid, bus.awready, bus.wready);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_async got rdy=%b%b%b valid=%b%b required 00000",
               bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid);
    end
    @(posedge clk); #4;
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
      errors++;
      $display("FAIL rstmid_release got rdy=%b%b%b valid=%b%b required 11100",
               bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_stale got bvalid/rvalid=%b%b required 00", bus.bvalid, bus.rvalid);
    end
    do_read(32'h40, rd, rr, lat);
    checks++;
    if (rd !== 32'h9999_0000) begin errors++; $display("FAIL rstmid_preserved got=%h required 99990000", rd); end
  endtask
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_strobe();
    test_order(1'b0, 32'h30, 32'h0A0B_0C0D);
    test_order(1'b1, 32'h34, 32'hC0FF_EE01);
    test_out_of_window();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
